// File: rtl/piso.sv
// Parallel-in serial-out framer: MSB-first serializer with a one-entry hold register for gapless frames.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit after the LSB of every frame.
module piso #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] p_in,
  output logic             in_ready,
  output logic             out_valid,
  output logic             s_out,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef PISO_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  function automatic logic [FRAME-1:0] make_frame(input logic [WIDTH-1:0] d);
`ifdef PISO_PARITY_EN
    return {d, even_parity(d)};
`else
    return d;
`endif
  endfunction

  state_t             state_r, next_state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [FRAME-1:0]   shift_r, shift_s;
  logic [WIDTH-1:0]   hold_r, hold_s;
  logic               full_r, full_s;
  logic               out_valid_r, out_valid_s;
  logic               s_out_r, s_out_s;
  logic               busy_r, busy_s;

  logic               accept_s;
  logic               last_s;
  logic               load_hold_s;
  logic               load_in_s;
  logic               write_hold_s;
  logic [FRAME-1:0]   frame_s;

  // cnt_r counts the bits still to come after the one currently on s_out
  assign accept_s     = in_valid & ~full_r & ~rst;
  assign last_s       = (state_r == SHIFT) & (cnt_r == CNT_ZERO);
  assign load_hold_s  = last_s & full_r;
  assign load_in_s    = accept_s & ((state_r == IDLE) | last_s);
  assign write_hold_s = accept_s & (state_r == SHIFT) & ~last_s;
  assign frame_s      = make_frame(load_hold_s ? hold_r : p_in);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s & ~full_r & ~accept_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output logic: next values of the registered serial outputs and busy
  always_comb begin
    out_valid_s = 1'b0;
    s_out_s     = 1'b0;
    if (load_hold_s | load_in_s) begin
      out_valid_s = 1'b1;
      s_out_s     = frame_s[FRAME-1];
    end else if ((state_r == SHIFT) & ~last_s) begin
      out_valid_s = 1'b1;
      s_out_s     = shift_r[FRAME-1];
    end else begin
      out_valid_s = 1'b0;
      s_out_s     = 1'b0;
    end
    busy_s = (next_state_s == SHIFT) | full_s;
  end

  // Datapath next values: shift register, bit counter and hold register
  always_comb begin
    shift_s = shift_r;
    cnt_s   = cnt_r;
    hold_s  = hold_r;
    full_s  = full_r;
    if (load_hold_s | load_in_s) begin
      shift_s = {frame_s[FRAME-2:0], 1'b0};
      cnt_s   = CNT_LAST;
    end else if ((state_r == SHIFT) & ~last_s) begin
      shift_s = {shift_r[FRAME-2:0], 1'b0};
      cnt_s   = cnt_r - CNT_ONE;
    end else begin
      shift_s = {FRAME{1'b0}};
      cnt_s   = CNT_ZERO;
    end
    if (write_hold_s) begin
      hold_s = p_in;
      full_s = 1'b1;
    end else if (load_hold_s) begin
      hold_s = hold_r;
      full_s = 1'b0;
    end else begin
      hold_s = hold_r;
      full_s = full_r;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r     <= {FRAME{1'b0}};
      cnt_r       <= CNT_ZERO;
      hold_r      <= {WIDTH{1'b0}};
      full_r      <= 1'b0;
      out_valid_r <= 1'b0;
      s_out_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      shift_r     <= shift_s;
      cnt_r       <= cnt_s;
      hold_r      <= hold_s;
      full_r      <= full_s;
      out_valid_r <= out_valid_s;
      s_out_r     <= s_out_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready  = ~full_r;
  assign out_valid = out_valid_r;
  assign s_out     = s_out_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_piso.sv
// Self-checking bench for piso (WIDTH=4): directed vector table, corner-case sequences,
// and randomized traffic against a queue-based frame model.
module tb_piso;
  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] p_in = '0;
  logic         in_ready, out_valid, s_out, busy;

  always #5 clk = ~clk;

  piso #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .p_in(p_in),
    .in_ready(in_ready), .out_valid(out_valid), .s_out(s_out), .busy(busy)
  );

  int total = 0;
  int passed = 0;

  // model: bits of the frame in flight (front = bit on s_out now), words waiting to start
  bit           cur_q[$];
  logic [W-1:0] wait_q[$];
  bit           seen_q[$];

  typedef struct {
    logic rst; logic iv; logic [W-1:0] d;
    logic ov; logic so; logic bz; logic rdy;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void load_frame(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) cur_q.push_back(w[i]);
`ifdef PISO_PARITY_EN
    cur_q.push_back(^w);
`endif
  endfunction

  task automatic step(input logic r, input logic v, input logic [W-1:0] d, output bit acc);
    bit took;
    rst = r; in_valid = v; p_in = d;
    acc = !r && v && (wait_q.size() == 0);
    @(posedge clk);
    if (r) begin
      cur_q.delete();
      wait_q.delete();
    end else begin
      took = 1'b0;
      if (cur_q.size() > 0) void'(cur_q.pop_front());
      if (cur_q.size() == 0) begin
        if (wait_q.size() > 0) load_frame(wait_q.pop_front());
        else if (acc) begin
          load_frame(d);
          took = 1'b1;
        end
      end
      if (acc && !took) wait_q.push_back(d);
    end
    #1;
    check("model out_valid", out_valid, cur_q.size() > 0);
    check("model s_out", s_out, (cur_q.size() > 0) ? cur_q[0] : 1'b0);
    check("model busy", busy, (cur_q.size() > 0) || (wait_q.size() > 0));
    check("model in_ready", in_ready, wait_q.size() == 0);
    if (out_valid === 1'b1) seen_q.push_back(s_out);
  endtask

  task automatic add(input logic r, input logic v, input logic [W-1:0] d,
                     input logic ov, input logic so, input logic bz, input logic rdy);
    vec_t e;
    e.rst = r; e.iv = v; e.d = d; e.ov = ov; e.so = so; e.bz = bz; e.rdy = rdy;
    tbl.push_back(e);
  endtask

  task automatic expect_stream(input string name, input logic [W-1:0] words[$]);
    bit exp_q[$];
    foreach (words[k]) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(words[k][i]);
`ifdef PISO_PARITY_EN
      exp_q.push_back(^words[k]);
`endif
    end
    check_int({name, " length"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
      check($sformatf("%s bit%0d", name, i), seen_q[i], exp_q[i]);
  endtask

  initial begin
    bit acc;
    int tries;
    logic [W-1:0] words[$];
    logic [W-1:0] rd;
    logic rv, rr;

    // reset then a single word
    add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PISO_PARITY_EN
    add(1'b0, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0,    1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0,    1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0,    1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0,    1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0, 1'b1);
`else
    add(1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0,    1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0,    1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0,    1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0,    1'b0, 1'b0, 1'b0, 1'b1);
    // back-to-back A then 5, no gap
    add(1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    seen_q.delete();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].d, acc);
      check($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ov);
      check($sformatf("vec%0d s_out", i), s_out, tbl[i].so);
      check($sformatf("vec%0d busy", i), busy, tbl[i].bz);
      check($sformatf("vec%0d in_ready", i), in_ready, tbl[i].rdy);
    end
`ifndef PISO_PARITY_EN
    // deserialized view of the first frame
    check_int("sipo word", {seen_q[0], seen_q[1], seen_q[2], seen_q[3]}, 4'b1011);
`endif

    // hold full: F must wait while the hold register is occupied
    seen_q.delete();
    step(1'b0, 1'b1, 4'hA, acc);
    step(1'b0, 1'b1, 4'h5, acc);
    check("hold_full in_ready", in_ready, 1'b0);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 20) begin
      step(1'b0, 1'b1, 4'hF, acc);
      tries++;
    end
    check_int("hold_full attempts", tries, FRAME);
    for (int i = 0; i < 3 * FRAME; i++) step(1'b0, 1'b0, 4'h0, acc);
    words = '{4'hA, 4'h5, 4'hF};
    expect_stream("hold_full stream", words);

    // mid-frame reset with a word held
    step(1'b0, 1'b1, 4'hC, acc);
    step(1'b0, 1'b1, 4'h5, acc);
    step(1'b1, 1'b1, 4'hF, acc);
    check("rst out_valid", out_valid, 1'b0);
    check("rst s_out", s_out, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    seen_q.delete();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'h0, acc);
    check_int("rst residual bits", seen_q.size(), 0);

    // randomized traffic, p_in held until accepted
    rv = 1'b0; rd = '0; acc = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (!rv || acc) begin
        rv = ($urandom_range(0, 3) != 0);
        rd = W'($urandom);
      end
      rr = ($urandom_range(0, 99) == 0);
      step(rr, rv, rd, acc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
